// File: rtl/dense_instr_decode.sv
// dense_instr_decode: parses a serial stream of instruction words for one
// dense-layer operation (header, weights, inputs, labels, backprop control)
// and presents every field in parallel with a single-cycle out_valid pulse.
module dense_instr_decode #(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int act_type_size          = 4,
  parameter int dense_type_size        = 4,
  parameter int cost_type_size         = 8,
  parameter int backprop_controll_size = 66
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [data_size-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [act_type_size-1:0]          act_type,
  output logic [dense_type_size-1:0]        dense_type,
  output logic [cost_type_size-1:0]         cost_type,
  output logic [data_size*size-1:0]         w,
  output logic                              load_w,
  output logic [data_size*size-1:0]         x,
  output logic [data_size*size-1:0]         label_out,
  output logic [backprop_controll_size-1:0] backprop_controll,
  output logic                              out_valid,
  output logic                              hdr_err,
  output logic                              busy
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_W,
    S_X,
    S_LBL,
    S_BP,
    S_EMIT
  } state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [1:0]                          bp_idx_q, bp_idx_d;
  logic [act_type_size-1:0]            act_type_q, act_type_d;
  logic [dense_type_size-1:0]          dense_type_q, dense_type_d;
  logic [cost_type_size-1:0]           cost_type_q, cost_type_d;
  logic [data_size*size-1:0]           w_q, w_d;
  logic [data_size*size-1:0]           x_q, x_d;
  logic [data_size*size-1:0]           label_q, label_d;
  logic [backprop_controll_size-1:0]   bp_q, bp_d;
  logic                                load_w_q, load_w_d;
  logic                                has_label_q, has_label_d;
  logic                                bp_en_q, bp_en_d;
  logic                                hdr_err_q, hdr_err_d;
  logic                                accept;
  int                                  bp_off;

  assign in_ready = (state_q != S_EMIT);
  assign accept   = in_valid && in_ready;

  // Next-state and field-update logic; every register holds unless a word is accepted.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bp_idx_d     = bp_idx_q;
    act_type_d   = act_type_q;
    dense_type_d = dense_type_q;
    cost_type_d  = cost_type_q;
    w_d          = w_q;
    x_d          = x_q;
    label_d      = label_q;
    bp_d         = bp_q;
    load_w_d     = load_w_q;
    has_label_d  = has_label_q;
    bp_en_d      = bp_en_q;
    hdr_err_d    = 1'b0;
    bp_off       = 0;

    // BP word order is a[15:0], a[31:16], b[15:0], b[31:16]; field_a sits above field_b.
    case (bp_idx_q)
      2'd0:    bp_off = 32;
      2'd1:    bp_off = 48;
      2'd2:    bp_off = 0;
      default: bp_off = 16;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_data[15:12] != 4'hD) begin
            hdr_err_d = 1'b1;
          end else begin
            act_type_d   = in_data[3:0];
            dense_type_d = in_data[7:4];
            load_w_d     = in_data[8];
            has_label_d  = in_data[9];
            bp_en_d      = in_data[10];
            idx_d        = '0;
            bp_idx_d     = '0;
            if (!in_data[9]) label_d = '0;
            bp_d = '0;
            if (in_data[10]) bp_d[65:64] = {1'b1, in_data[11]};
            state_d = S_HDR1;
          end
        end
      end
      S_HDR1: begin
        if (accept) begin
          cost_type_d = in_data[7:0];
          state_d     = load_w_q ? S_W : S_X;
        end
      end
      S_W: begin
        if (accept) begin
          w_d[data_size*idx_q +: data_size] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_X;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_X: begin
        if (accept) begin
          x_d[data_size*idx_q +: data_size] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (has_label_q)  state_d = S_LBL;
            else if (bp_en_q) state_d = S_BP;
            else              state_d = S_EMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LBL: begin
        if (accept) begin
          label_d[data_size*idx_q +: data_size] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = bp_en_q ? S_BP : S_EMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_BP: begin
        if (accept) begin
          bp_d[bp_off +: 16] = in_data[15:0];
          if (bp_idx_q == 2'd3) begin
            bp_idx_d = '0;
            state_d  = S_EMIT;
          end else begin
            bp_idx_d = bp_idx_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      bp_idx_q     <= '0;
      act_type_q   <= '0;
      dense_type_q <= '0;
      cost_type_q  <= '0;
      w_q          <= '0;
      x_q          <= '0;
      label_q      <= '0;
      bp_q         <= '0;
      load_w_q     <= 1'b0;
      has_label_q  <= 1'b0;
      bp_en_q      <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bp_idx_q     <= bp_idx_d;
      act_type_q   <= act_type_d;
      dense_type_q <= dense_type_d;
      cost_type_q  <= cost_type_d;
      w_q          <= w_d;
      x_q          <= x_d;
      label_q      <= label_d;
      bp_q         <= bp_d;
      load_w_q     <= load_w_d;
      has_label_q  <= has_label_d;
      bp_en_q      <= bp_en_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign act_type          = act_type_q;
  assign dense_type        = dense_type_q;
  assign cost_type         = cost_type_q;
  assign w                 = w_q;
  assign load_w            = load_w_q;
  assign x                 = x_q;
  assign label_out         = label_q;
  assign backprop_controll = bp_q;
  assign out_valid         = (state_q == S_EMIT);
  assign hdr_err           = hdr_err_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_dense_instr_decode.sv
// Scoreboard bench for dense_instr_decode: the stimulus thread pushes the
// hand-computed decode result of each instruction; a monitor pops and
// compares whenever out_valid is presented.
module tb_dense_instr_decode;

  typedef struct packed {
    logic [3:0]  act;
    logic [3:0]  dense;
    logic [7:0]  cost;
    logic [47:0] w;
    logic        load_w;
    logic [47:0] x;
    logic [47:0] lbl;
    logic [65:0] bp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  act_type;
  logic [3:0]  dense_type;
  logic [7:0]  cost_type;
  logic [47:0] w;
  logic        load_w;
  logic [47:0] x;
  logic [47:0] label_out;
  logic [65:0] backprop_controll;
  logic        out_valid;
  logic        hdr_err;
  logic        busy;

  exp_t        expQ[$];
  exp_t        monExp;
  exp_t        e1, e2, e4;
  logic [15:0] wordBuf [0:19];
  int          checkCount = 0;
  int          passCount  = 0;
  int          hdrSeen    = 0;
  int          hdrExp     = 0;

  dense_instr_decode dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .act_type(act_type), .dense_type(dense_type),
    .cost_type(cost_type), .w(w), .load_w(load_w), .x(x), .label_out(label_out),
    .backprop_controll(backprop_controll), .out_valid(out_valid),
    .hdr_err(hdr_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Drive wordBuf[0..n-1] one accepted word at a time, optionally idling between words.
  task automatic applyStimulus(input int n, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = wordBuf[i];
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) checkOutput("in_ready_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic loadScen1();
    wordBuf[0] = 16'hD012; wordBuf[1] = 16'h0005;
    wordBuf[2] = 16'h0001; wordBuf[3] = 16'h0002; wordBuf[4] = 16'h0003;
  endtask

  task automatic loadScen2();
    wordBuf[0]  = 16'hDF13; wordBuf[1]  = 16'h0007;
    wordBuf[2]  = 16'h000A; wordBuf[3]  = 16'h000B; wordBuf[4]  = 16'h000C;
    wordBuf[5]  = 16'h0001; wordBuf[6]  = 16'h0002; wordBuf[7]  = 16'h0003;
    wordBuf[8]  = 16'h0004; wordBuf[9]  = 16'h0005; wordBuf[10] = 16'h0006;
    wordBuf[11] = 16'h5678; wordBuf[12] = 16'h1234;
    wordBuf[13] = 16'hDEF0; wordBuf[14] = 16'h9ABC;
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 1'b1, 1'b0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("act_type", act_type, monExp.act);
          checkOutput("dense_type", dense_type, monExp.dense);
          checkOutput("cost_type", cost_type, monExp.cost);
          checkOutput("w", w, monExp.w);
          checkOutput("load_w", load_w, monExp.load_w);
          checkOutput("x", x, monExp.x);
          checkOutput("label_out", label_out, monExp.lbl);
          checkOutput("backprop_controll", backprop_controll, monExp.bp);
          checkOutput("in_ready_in_emit", in_ready, 1'b0);
        end
      end
      if (hdr_err) hdrSeen++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    e1 = '{act: 4'h2, dense: 4'h1, cost: 8'h05, w: 48'h0, load_w: 1'b0,
           x: 48'h0003_0002_0001, lbl: 48'h0, bp: 66'h0};
    e2 = '{act: 4'h3, dense: 4'h1, cost: 8'h07, w: 48'h000C_000B_000A, load_w: 1'b1,
           x: 48'h0003_0002_0001, lbl: 48'h0006_0005_0004,
           bp: {2'b11, 32'h1234_5678, 32'h9ABC_DEF0}};
    e4 = '{act: 4'h2, dense: 4'h1, cost: 8'h05, w: 48'h000C_000B_000A, load_w: 1'b0,
           x: 48'h0009_0008_0007, lbl: 48'h0, bp: 66'h0};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_hdr_err", hdr_err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_fields", {act_type, dense_type, cost_type, load_w}, 17'h0);
    checkOutput("rst_vectors", {w, x}, 96'h0);
    checkOutput("rst_label_bp", {label_out, backprop_controll}, 114'h0);
    rst_n = 1'b1;

    $display("[TB] basic instruction, no w/label/bp");
    loadScen1(); expQ.push_back(e1); applyStimulus(5, 1'b0);

    $display("[TB] full instruction with w, label and backprop");
    loadScen2(); expQ.push_back(e2); applyStimulus(15, 1'b0);

    $display("[TB] bad opcode is dropped");
    wordBuf[0] = 16'h1000; hdrExp++; applyStimulus(1, 1'b0);
    checkOutput("bad_hdr_busy", busy, 1'b0);
    checkOutput("bad_hdr_in_ready", in_ready, 1'b1);
    e1.w = 48'h000C_000B_000A;
    loadScen1(); expQ.push_back(e1); applyStimulus(5, 1'b0);

    $display("[TB] w retention across load_w=0");
    loadScen2(); expQ.push_back(e2); applyStimulus(15, 1'b0);
    loadScen1(); wordBuf[2] = 16'h0007; wordBuf[3] = 16'h0008; wordBuf[4] = 16'h0009;
    expQ.push_back(e4); applyStimulus(5, 1'b0);

    $display("[TB] full instruction with in_valid gaps");
    loadScen2(); expQ.push_back(e2); applyStimulus(15, 1'b1);

    $display("[TB] reset mid-instruction");
    loadScen2(); applyStimulus(8, 1'b0);
    checkOutput("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    checkOutput("mid_rst_fields", {act_type, dense_type, cost_type, load_w}, 17'h0);
    checkOutput("mid_rst_vectors", {w, x}, 96'h0);
    checkOutput("mid_rst_label_bp", {label_out, backprop_controll}, 114'h0);
    repeat (3) @(posedge clk);
    #1;
    e1.w = 48'h0;
    loadScen1(); expQ.push_back(e1); applyStimulus(5, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_expected", expQ.size(), 0);
    checkOutput("hdr_err_pulses", hdrSeen, hdrExp);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
